// File: rtl/shift_operand_stage.sv
// ---------------------------------------------------------------------------
// shift_operand_stage
//
// Pipeline stage in front of the barrel shifter. It decodes the 12-bit
// data-processing operand2 field together with the Rm/Rs register values into
// the shifter operand, 5-bit amount, shift type and a force-to-zero flag, then
// registers the result behind a valid/ready handshake with a 2-entry skid
// buffer. Both in_ready and all outputs come straight from flops.
//
// DW must be 32 so that a 5-bit amount covers the full shift range.
//
// Optional feature macro: SHIFT_STAGE_STATS_EN
//   defined   : stat_acc counts accepts, stat_stall counts cycles with
//               out_valid & ~out_ready (both wrap, both cleared by reset)
//   undefined : stat_acc / stat_stall tied to 0, no counter flops
//
// Ports
//   clk        in   clock, all state changes on posedge
//   reset      in   synchronous active-low reset
//   in_valid   in   upstream operand valid
//   in_ready   out  stage can accept (registered)
//   imm_sel    in   instruction I bit, 1 = immediate-rotate form
//   op2        in   operand2 field instr[11:0]
//   rm_val     in   value of Rm
//   rs_val     in   value of Rs, only [7:0] used
//   out_valid  out  shifter inputs valid
//   out_ready  in   downstream accepts
//   sh_a       out  shifter operand
//   sh_shamt   out  shift amount
//   sh_type    out  00 LSL, 01 LSR, 10 ASR, 11 ROR
//   sh_zero    out  downstream forces the shift result to 0
//   stat_acc   out  accepted-operation count
//   stat_stall out  stall-cycle count
// ---------------------------------------------------------------------------
module shift_operand_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             imm_sel,
  input  logic [11:0]      op2,
  input  logic [DW-1:0]    rm_val,
  input  logic [DW-1:0]    rs_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    sh_a,
  output logic [4:0]       sh_shamt,
  output logic [1:0]       sh_type,
  output logic             sh_zero,
  output logic [CNT_W-1:0] stat_acc,
  output logic [CNT_W-1:0] stat_stall
);

  typedef struct packed {
    logic          zero;
    logic [1:0]    typ;
    logic [4:0]    shamt;
    logic [DW-1:0] a;
  } op_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;
  op_t    main_q, skid_q, dec_d;
  logic   out_valid_q, in_ready_q;
  logic   accept_s, xfer_s;
  logic   load_main_dec_s, load_main_skid_s, load_skid_s;

  logic [1:0] t_s;
  logic [4:0] n_s;
  logic [7:0] amt_s;
  logic       amt_big_s;
  logic       unused_rs_s;

  assign t_s       = op2[6:5];
  assign n_s       = op2[11:7];
  assign amt_s     = rs_val[7:0];
  assign amt_big_s = |amt_s[7:5];
  // Upper Rs bits never influence the result.
  assign unused_rs_s = ^rs_val[DW-1:8];

  // Operand2 decode into shifter operand / amount / type / zero flag.
  always_comb begin
    dec_d       = '0;
    dec_d.a     = rm_val;
    dec_d.typ   = t_s;
    dec_d.shamt = 5'd0;
    dec_d.zero  = 1'b0;
    if (imm_sel) begin
      // 8-bit immediate rotated right by twice the 4-bit rotate field.
      dec_d.a     = {{(DW-8){1'b0}}, op2[7:0]};
      dec_d.typ   = 2'b11;
      dec_d.shamt = {op2[11:8], 1'b0};
    end else if (!op2[4]) begin
      if (n_s == 5'd0) begin
        case (t_s)
          // LSR #32: every bit shifted out.
          2'b01:   dec_d.zero  = 1'b1;
          // ASR #32 gives the same result as ASR #31 (sign replication).
          2'b10:   dec_d.shamt = 5'd31;
          // LSL #0, and the RRX encoding passed on as ROR #0.
          default: dec_d.shamt = 5'd0;
        endcase
      end else begin
        dec_d.shamt = n_s;
      end
    end else begin
      if (amt_s == 8'd0) begin
        // Zero register amount is a pass-through regardless of type.
        dec_d.typ   = 2'b00;
        dec_d.shamt = 5'd0;
      end else begin
        case (t_s)
          2'b00, 2'b01: begin
            dec_d.zero  = amt_big_s;
            dec_d.shamt = amt_big_s ? 5'd0 : amt_s[4:0];
          end
          2'b10:   dec_d.shamt = amt_big_s ? 5'd31 : amt_s[4:0];
          // Rotation is modulo 32; a multiple of 32 becomes the identity ROR 0.
          default: dec_d.shamt = amt_s[4:0];
        endcase
      end
    end
  end

  assign accept_s = in_valid & in_ready_q;
  assign xfer_s   = out_valid_q & out_ready;

  // Skid-buffer next state and register load selection.
  always_comb begin
    state_d          = state_q;
    load_main_dec_s  = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d         = ST_ONE;
          load_main_dec_s = 1'b1;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && xfer_s) begin
          load_main_dec_s = 1'b1;
        end else if (accept_s) begin
          state_d     = ST_TWO;
          load_skid_s = 1'b1;
        end else if (xfer_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (xfer_s) begin
          state_d          = ST_ONE;
          load_main_skid_s = 1'b1;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Buffer state, registered handshake flags and main/skid data registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_TWO);
      if (load_main_dec_s) begin
        main_q <= dec_d;
      end else if (load_main_skid_s) begin
        main_q <= skid_q;
      end else begin
        main_q <= main_q;
      end
      if (load_skid_s) begin
        skid_q <= dec_d;
      end else begin
        skid_q <= skid_q;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sh_a      = main_q.a;
  assign sh_shamt  = main_q.shamt;
  assign sh_type   = main_q.typ;
  assign sh_zero   = main_q.zero;

`ifdef SHIFT_STAGE_STATS_EN
  logic [CNT_W-1:0] stat_acc_q, stat_stall_q;

  // Accept and stall counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_acc_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_acc_q   <= accept_s ? stat_acc_q + {{(CNT_W-1){1'b0}}, 1'b1} : stat_acc_q;
      stat_stall_q <= (out_valid_q && !out_ready) ?
                      stat_stall_q + {{(CNT_W-1){1'b0}}, 1'b1} : stat_stall_q;
    end
  end

  assign stat_acc   = stat_acc_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_acc   = '0;
  assign stat_stall = '0;
`endif

endmodule
